// File: rtl/guess_game_core.sv
// Guessing-game engine: one-hot lamp that steps on an internal counter, the player
// must press the matching button; tracks score and lives and declares win or lose.
module guess_game_core #(
    parameter int N           = 4,
    parameter int STEP_CYCLES = 50_000_000,
    parameter int STEP_DEC    = 5_000_000,
    parameter int STEP_MIN    = 10_000_000,
    parameter int TARGET      = 8,
    parameter int LIVES       = 3,
    parameter int SCORE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       b,
    input  logic               mode,
    input  logic               start,
    output logic [N-1:0]       y,
    output logic               win,
    output logic               lose,
    output logic               playing,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         lives
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(STEP_CYCLES + 1);

    localparam logic [CW-1:0]      PERIOD_INIT = CW'(STEP_CYCLES);
    localparam logic [CW-1:0]      DEC_C       = CW'(STEP_DEC);
    localparam logic [CW-1:0]      MIN_C       = CW'(STEP_MIN);
    localparam logic [SCORE_W-1:0] TARGET_C    = SCORE_W'(TARGET);
    localparam logic [2:0]         LIVES_C     = 3'(LIVES);
    localparam logic [N-1:0]       ONE         = N'(1);

    typedef enum logic [1:0] {IDLE, RUN, WIN, LOSE} state_t;

    state_t             state, state_n;
    logic [PW-1:0]      pos, pos_n, pos_step;
    logic [CW-1:0]      cnt, cnt_n;
    logic [CW-1:0]      period, period_n;
    logic [7:0]         lfsr, lfsr_n;
    logic [N-1:0]       b_q;
    logic               start_q;
    logic [N-1:0]       y_n;
    logic [SCORE_W-1:0] score_n;
    logic [2:0]         lives_n;
    logic [N-1:0]       press;
    logic               start_rise;
    logic               hit;
    logic               miss;
    logic               tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pos     <= '0;
            cnt     <= '0;
            period  <= PERIOD_INIT;
            lfsr    <= 8'h01;
            b_q     <= '0;
            start_q <= 1'b0;
            y       <= '0;
            score   <= '0;
            lives   <= LIVES_C;
        end else begin
            state   <= state_n;
            pos     <= pos_n;
            cnt     <= cnt_n;
            period  <= period_n;
            lfsr    <= lfsr_n;
            b_q     <= b;
            start_q <= start;
            y       <= y_n;
            score   <= score_n;
            lives   <= lives_n;
        end
    end

    // A hit is judged against the lamp as currently shown, so it takes priority
    // over a step tick landing in the same cycle and the position moves only once.
    always_comb begin
        press      = b & ~b_q;
        start_rise = start & ~start_q;
        lfsr_n     = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
        tick       = (cnt == period - CW'(1));
        hit        = (press != '0) && (press == y);
        miss       = (press != '0) && !hit;

        if (mode) begin
            pos_step = (lfsr[PW-1:0] == pos) ? pos + PW'(1) : lfsr[PW-1:0];
        end else begin
            pos_step = pos + PW'(1);
        end

        state_n  = state;
        pos_n    = pos;
        cnt_n    = cnt;
        period_n = period;
        score_n  = score;
        lives_n  = lives;

        if (start_rise) begin
            state_n  = RUN;
            pos_n    = '0;
            cnt_n    = '0;
            period_n = PERIOD_INIT;
            score_n  = '0;
            lives_n  = LIVES_C;
        end else begin
            case (state)
                RUN: begin
                    if (hit) begin
                        if (score != '1) begin
                            score_n = score + SCORE_W'(1);
                        end
                        pos_n = pos_step;
                        cnt_n = '0;
                        if (period >= MIN_C && (period - MIN_C) >= DEC_C) begin
                            period_n = period - DEC_C;
                        end else begin
                            period_n = MIN_C;
                        end
                        if (score_n == TARGET_C) begin
                            state_n = WIN;
                        end
                    end else begin
                        if (tick) begin
                            cnt_n = '0;
                            pos_n = pos_step;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                        if (miss) begin
                            lives_n = lives - 3'd1;
                            if (lives_n == 3'd0) begin
                                state_n = LOSE;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        y_n = (state_n == RUN) ? (ONE << pos_n) : '0;
    end

    assign win     = (state == WIN);
    assign lose    = (state == LOSE);
    assign playing = (state == RUN);

endmodule

// File: tb/tb_guess_game_core.sv
// Directed bench for guess_game_core: a cycle-level reference model pushes expected
// outputs into a scoreboard queue, which is popped and compared after each edge.
module tb_guess_game_core;

    localparam int N = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] b     = '0;
    logic       mode  = 1'b0;
    logic       start = 1'b0;
    logic [3:0] y;
    logic       win;
    logic       lose;
    logic       playing;
    logic [3:0] score;
    logic [2:0] lives;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] y;
        logic       win;
        logic       lose;
        logic       playing;
        logic [3:0] score;
        logic [2:0] lives;
    } exp_t;

    exp_t sb_q[$];

    int         m_state;
    int         m_pos;
    int         m_score;
    int         m_lives;
    int         m_period;
    int         m_cnt;
    logic [7:0] m_lfsr;
    logic [3:0] m_bq;
    logic       m_sq;
    bit         m_ticked;

    always #5 clk = ~clk;

    guess_game_core #(
        .N(N), .STEP_CYCLES(10), .STEP_DEC(2), .STEP_MIN(4),
        .TARGET(3), .LIVES(2), .SCORE_W(4)
    ) dut (
        .clk(clk), .reset(reset), .b(b), .mode(mode), .start(start),
        .y(y), .win(win), .lose(lose), .playing(playing),
        .score(score), .lives(lives)
    );

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_pos    = 0;
        m_score  = 0;
        m_lives  = 2;
        m_period = 10;
        m_cnt    = 0;
        m_lfsr   = 8'h01;
        m_bq     = '0;
        m_sq     = 1'b0;
        m_ticked = 0;
    endtask

    task automatic model_step(input logic [3:0] bv, input logic sv, input logic mv);
        logic [3:0] press;
        logic       sr;
        logic [7:0] nl;
        int         r;
        int         adv;
        bit         hit;
        bit         miss;
        bit         tick;
        press = bv & ~m_bq;
        sr    = sv & ~m_sq;
        nl    = {1'b0, m_lfsr[7:1]};
        if (m_lfsr[0]) nl = nl ^ 8'hB8;
        r   = int'(m_lfsr[1:0]);
        adv = mv ? ((r == m_pos) ? (m_pos + 1) % N : r) : (m_pos + 1) % N;
        m_ticked = 0;
        if (sr) begin
            m_state  = 1;
            m_pos    = 0;
            m_score  = 0;
            m_lives  = 2;
            m_period = 10;
            m_cnt    = 0;
        end else if (m_state == 1) begin
            hit  = (press != 0) && (int'(press) == (1 << m_pos));
            miss = (press != 0) && !hit;
            tick = (m_cnt == m_period - 1);
            if (hit) begin
                m_score  = (m_score < 15) ? m_score + 1 : 15;
                m_pos    = adv;
                m_cnt    = 0;
                m_period = (m_period - 2 > 4) ? m_period - 2 : 4;
                if (m_score == 3) m_state = 2;
            end else begin
                if (tick) begin
                    m_cnt    = 0;
                    m_pos    = adv;
                    m_ticked = 1;
                end else begin
                    m_cnt++;
                end
                if (miss) begin
                    m_lives--;
                    if (m_lives == 0) m_state = 3;
                end
            end
        end
        m_bq   = bv;
        m_sq   = sv;
        m_lfsr = nl;
    endtask

    task automatic apply_stimulus(input logic [3:0] bv, input logic sv, input logic mv);
        exp_t e;
        b     = bv;
        start = sv;
        mode  = mv;
        model_step(bv, sv, mv);
        e.y       = (m_state == 1) ? 4'(1 << m_pos) : 4'b0000;
        e.win     = (m_state == 2);
        e.lose    = (m_state == 3);
        e.playing = (m_state == 1);
        e.score   = 4'(m_score);
        e.lives   = 3'(m_lives);
        sb_q.push_back(e);
    endtask

    task automatic check_output();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_val("y", y, e.y);
            check_val("win", win, e.win);
            check_val("lose", lose, e.lose);
            check_val("playing", playing, e.playing);
            check_val("score", score, e.score);
            check_val("lives", lives, e.lives);
        end
    endtask

    task automatic cycle(input logic [3:0] bv, input logic sv, input logic mv);
        apply_stimulus(bv, sv, mv);
        check_output();
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_y"}, y, 4'b0000);
        check_val({tag, "_win"}, win, 1'b0);
        check_val({tag, "_lose"}, lose, 1'b0);
        check_val({tag, "_playing"}, playing, 1'b0);
        check_val({tag, "_score"}, score, 4'd0);
        check_val({tag, "_lives"}, lives, 3'd2);
    endtask

    initial begin
        logic [3:0] prev_y;
        int         ticks;
        int         budget;

        model_reset();
        #1 reset = 1'b0;
        #1 check_reset_values("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        cycle(4'b0000, 1'b1, 1'b0);
        check_val("start_y", y, 4'b0001);
        check_val("start_playing", playing, 1'b1);
        check_val("start_lives", lives, 3'd2);

        // Initial period of 10: lamp holds for 9 more cycles, moves on the 10th.
        repeat (9) cycle(4'b0000, 1'b0, 1'b0);
        check_val("step_hold", y, 4'b0001);
        cycle(4'b0000, 1'b0, 1'b0);
        check_val("step1", y, 4'b0010);
        repeat (30) cycle(4'b0000, 1'b0, 1'b0);
        check_val("step_wrap", y, 4'b0001);

        cycle(4'b0001, 1'b0, 1'b0);
        check_val("hit1_score", score, 4'd1);
        check_val("hit1_y", y, 4'b0010);
        repeat (7) cycle(4'b0000, 1'b0, 1'b0);
        check_val("period8_hold", y, 4'b0010);
        cycle(4'b0000, 1'b0, 1'b0);
        check_val("period8_step", y, 4'b0100);

        cycle(4'b0100, 1'b0, 1'b0);
        check_val("hit2_y", y, 4'b1000);
        repeat (5) cycle(4'b0000, 1'b0, 1'b0);
        check_val("period6_hold", y, 4'b1000);
        cycle(4'b0000, 1'b0, 1'b0);
        check_val("period6_step", y, 4'b0001);

        cycle(4'b0001, 1'b0, 1'b0);
        check_val("win_flag", win, 1'b1);
        check_val("win_y", y, 4'b0000);
        check_val("win_score", score, 4'd3);
        repeat (5) cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0001, 1'b0, 1'b0);
        check_val("win_frozen_score", score, 4'd3);

        cycle(4'b0000, 1'b1, 1'b0);
        check_val("restart_score", score, 4'd0);
        cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0100, 1'b0, 1'b0);
        check_val("miss1_lives", lives, 3'd1);
        check_val("miss1_y", y, 4'b0001);
        cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0011, 1'b0, 1'b0);
        check_val("miss2_lives", lives, 3'd0);
        check_val("miss2_lose", lose, 1'b1);
        check_val("miss2_y", y, 4'b0000);
        cycle(4'b0000, 1'b0, 1'b0);

        cycle(4'b0000, 1'b1, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0);
        repeat (30) cycle(4'b0001, 1'b0, 1'b0);
        check_val("hold_score", score, 4'd1);
        check_val("hold_lives", lives, 3'd2);
        cycle(4'b0000, 1'b0, 1'b0);

        // Line up a hit with the cycle in which the step counter wraps.
        budget = 0;
        while (m_cnt != m_period - 1 && budget < 50) begin
            cycle(4'b0000, 1'b0, 1'b0);
            budget++;
        end
        check_val("tick_align_bound", (budget < 50), 1'b1);
        prev_y = y;
        cycle(4'(1 << m_pos), 1'b0, 1'b0);
        check_val("tick_hit_y", y, {prev_y[2:0], prev_y[3]});
        check_val("tick_hit_score", score, 4'd2);

        ticks  = 0;
        budget = 0;
        prev_y = y;
        while (ticks < 40 && budget < 1000) begin
            cycle(4'b0000, 1'b0, 1'b1);
            check_val("rand_onehot", $onehot(y), 1'b1);
            if (m_ticked) begin
                ticks++;
                check_val("rand_norepeat", (y != prev_y), 1'b1);
            end
            prev_y = y;
            budget++;
        end
        check_val("rand_ticks", ticks, 40);

        #2 reset = 1'b0;
        #1 check_reset_values("midreset");
        model_reset();
        sb_q.delete();
        @(negedge clk);
        reset = 1'b1;
        cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);
        check_val("fresh_playing", playing, 1'b1);
        check_val("fresh_y", y, 4'b0001);
        check_val("fresh_score", score, 4'd0);
        repeat (3) cycle(4'b0000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/guess_game_core.md
# guess_game_core

Parametrised guessing-game engine that replaces the fixed four-button guess FSM and its external divided-clock mux. It runs entirely on the system clock, with an internal step counter, and drives a one-hot lamp across N positions. The player must press the button matching the lit lamp. The engine keeps score and lives and declares win or lose. It sits between the button debouncers (inputs already debounced and synchronous to `clk`) and the LED/display drivers.

## Interface
- `N`, 4 — number of lamp/button positions; legal values 2, 4, 8, 16
- `STEP_CYCLES`, 50_000_000 — initial clock cycles per lamp step
- `STEP_DEC`, 5_000_000 — step-period reduction applied on each hit
- `STEP_MIN`, 10_000_000 — floor on the step period
- `TARGET`, 8 — hits required to win; 1..2^SCORE_W-1
- `LIVES`, 3 — misses allowed before losing; 1..7
- `SCORE_W`, 4 — score counter width
- `clk`  in  1  system clock; all logic is on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `b`  in  N  debounced buttons, active-high, synchronous to `clk`
- `mode`  in  1  0 = sequential rotation, 1 = pseudo-random position; sampled at each step
- `start`  in  1  level; a rising edge starts or restarts a game
- `y`  out  N  one-hot lit lamp; all zero when not running
- `win`  out  1  high while in WIN
- `lose`  out  1  high while in LOSE
- `playing`  out  1  high while in RUN
- `score`  out  SCORE_W  hits this game
- `lives`  out  3  remaining lives

## Operation
- States: IDLE, RUN, WIN, LOSE.
  - IDLE to RUN on a `start` rising edge.
  - RUN to WIN when a hit makes `score == TARGET`.
  - RUN to LOSE when a miss makes `lives == 0`.
  - WIN or LOSE to RUN on a `start` rising edge.
- Entering RUN, all in the same cycle: `y = 1` (position 0), `score = 0`, `lives = LIVES`, period = `STEP_CYCLES`, step counter = 0.
- Edge detection: `b_q` and `start_q` register the inputs every cycle. `press = b & ~b_q`, `start_rise = start & ~start_q`.
- Step counter runs in RUN only. When it reaches period−1 it wraps to 0 and issues a step tick.
- On a step tick:
  - `mode` 0: next position = (pos+1) mod N.
  - `mode` 1: next position = `lfsr[log2(N)-1:0]`; if that equals pos, use (pos+1) mod N instead.
- LFSR: 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1, reset value 8'h01, advances every cycle in every state.
- Hit: `press` is one-hot and equal to `y`. Effects:
  - `score` +1.
  - Position advances immediately, by the same rule as a step tick.
  - Step counter clears to 0.
  - Period = max(period − `STEP_DEC`, `STEP_MIN`).
- Miss: `press` is non-zero and not equal to `y`, including multi-bit presses. Effects: `lives` −1; position and step counter unaffected.
- Same-cycle press and step tick: judge the press against the pre-tick `y`. A hit suppresses the tick advance, so the position advances once. A miss lets the tick advance proceed.
- `start_rise` during RUN restarts the game; any press in that cycle is ignored.
- Presses in IDLE, WIN or LOSE are ignored.
- In WIN and LOSE, `y`, `score` and `lives` freeze at their final values, except that `y` = 0.
- `score` saturates; it never wraps.

## Timing
- Reset values: state IDLE; `y` = 0; `win` = `lose` = `playing` = 0; `score` = 0; `lives` = `LIVES`; period = `STEP_CYCLES`; LFSR = 8'h01; `b_q` = 0; `start_q` = 0.
- Reset assertion mid-game returns to the reset values asynchronously. The first `start` edge after release is honoured.
- All outputs are registered.
- `b` rises before edge k: `score`/`lives`/`y` update at edge k, visible one cycle after `b` rose.
- `start` rises before edge k: `playing` = 1 and `y` = 1 after edge k.
- Step tick: `y` changes exactly period cycles after the last step or hit.
- `win`/`lose` assert at the same edge as the final `score`/`lives` update.
- A button held high counts once; it must be released and pressed again to count.

## Test plan
- Bench parameters for all scenarios: N=4, STEP_CYCLES=10, STEP_DEC=2, STEP_MIN=4, TARGET=3, LIVES=2.
- Reset, then pulse `start` → `y`=4'b0001, `playing`=1, `lives`=2; with `mode`=0, `y` steps 0001→0010→0100→1000→0001, every 10 cycles.
- Press `b`=4'b0001 while `y`=0001 → next cycle: `score`=1, `y`=0010, counter cleared, next step after 8 cycles. Second hit: period 6. Third hit: `win`=1, `y`=0, `score`=3.
- Press `b`=4'b0100 while `y`=0001, then `b`=4'b0011 → `lives` 2→1→0, `lose`=1 on the second miss, `y` frozen to 0.
- Hold `b`=0001 for 30 cycles across steps → exactly one hit or miss recorded. Hit pressed on the same cycle as the step tick → `y` advances by exactly one position.
- `mode`=1 for 40 steps → `y` is always one-hot and never repeats consecutively. Assert `reset` low mid-game → all outputs at reset values within the same cycle; `start` after release → a fresh game.
